mod_adder_pipe: RTL and testbench

- Parametrised, pipelined modulo adder. Computes (a + b) mod M, where M = 2^WIDTH − k.
- k is supplied per transaction, so each operand pair carries its own modulus.
- Three registered stages: preprocessing (g/p/h plus k-enveloped g'/p'/h'), parallel-prefix carry, and sum selection.
- Valid/ready handshake on both sides, so it drops into streaming datapaths. Throughput is one result per cycle.

---
 rtl/mod_adder_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_mod_adder_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_adder_pipe.sv
// mod_adder_pipe: three-stage pipelined modulo adder, sum = (a + b) mod (2^WIDTH - k).
// Stage 1 forms bitwise g/p/h for a+b and for the carry-saved a+b+k.
// Stage 2 resolves prefix carries for both vectors.
// Stage 3 selects the reduced or unreduced sum.
// Optional subtraction support is enabled by defining MOD_ADDER_SUB_EN.
module mod_adder_pipe #(
  parameter int WIDTH     = 7,
  parameter int PREFIX_KS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] k,
`ifdef MOD_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             wrap
);

  localparam int N = WIDTH + 1;

  // Group generate from bit 0 up to each position (carry-in already folded into g[0]).
  function automatic logic [N-1:0] prefix_carry(input logic [N-1:0] g, input logic [N-1:0] p);
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    int j;
    gg = g;
    pp = p;
    if (PREFIX_KS != 0) begin
      for (int d = 1; d < N; d = d * 2) begin
        gn = gg;
        pn = pp;
        for (int i = d; i < N; i++) begin
          gn[i] = gg[i] | (pp[i] & gg[i-d]);
          pn[i] = pp[i] & pp[i-d];
        end
        gg = gn;
        pp = pn;
      end
    end else begin
      for (int l = 0; (1 << l) < N; l++) begin
        gn = gg;
        pn = pp;
        for (int i = 0; i < N; i++) begin
          if ((i & (1 << l)) != 0) begin
            j     = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
            gn[i] = gg[i] | (pp[i] & gg[j]);
            pn[i] = pp[i] & pp[j];
          end else begin
            gn[i] = gg[i];
            pn[i] = pp[i];
          end
        end
        gg = gn;
        pp = pn;
      end
    end
    return gg;
  endfunction

  logic advance_s;

  // Stage 1 combinational operands
  logic             cin_s;
  logic [WIDTH-1:0] y1_s;
  logic [WIDTH-1:0] b2_s;
  logic [WIDTH-1:0] k2_s;
  logic [WIDTH-1:0] hs_s;
  logic [WIDTH-1:0] cs_s;
  logic [WIDTH-1:0] h1_s;
  logic [WIDTH-1:0] g1_s;
  logic [WIDTH-1:0] p1_s;
  logic [N-1:0]     x2_s;
  logic [N-1:0]     y2_s;
  logic [N-1:0]     h2_s;
  logic [N-1:0]     g2_s;
  logic [N-1:0]     p2_s;

  // Stage registers
  logic             v1_r;
  logic             cin_r;
  logic [WIDTH-1:0] h1_r;
  logic [WIDTH-1:0] g1_r;
  logic [WIDTH-1:0] p1_r;
  logic [N-1:0]     h2_r;
  logic [N-1:0]     g2_r;
  logic [N-1:0]     p2_r;
  logic             v2_r;
  logic [WIDTH-1:0] h1b_r;
  logic [N-1:0]     h2b_r;
  logic [N-1:0]     c1_r;
  logic [N-1:0]     c2_r;
`ifdef MOD_ADDER_SUB_EN
  logic             sub2_r;
`endif

  logic [N-1:0]     gc1_s;
  logic [N-1:0]     gc2_s;
  logic [WIDTH-1:0] sum1_s;
  logic [WIDTH-1:0] sum2_s;
  logic             wrap_s;
  logic [WIDTH-1:0] sum_s;

  // One global enable: the whole pipe moves only when the output slot can drain.
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s;

  // Build vector 1 (a +/- b) and carry-save vector 2 (a + b + k, or a - b - k).
  always_comb begin
`ifdef MOD_ADDER_SUB_EN
    cin_s = sub;
    y1_s  = sub ? ~b : b;
    k2_s  = sub ? ~k : k;
`else
    cin_s = 1'b0;
    y1_s  = b;
    k2_s  = k;
`endif
    b2_s = y1_s;
    hs_s = a ^ b2_s ^ k2_s;
    cs_s = (a & b2_s) | (a & k2_s) | (b2_s & k2_s);
    // Subtraction needs +2 (two's complement of b and k): one +1 via the free
    // LSB of the shifted carry vector, the other via carry-in.
    x2_s = {1'b0, hs_s};
    y2_s = {cs_s, cin_s};
    h1_s = a ^ y1_s;
    g1_s = a & y1_s;
    p1_s = a | y1_s;
    g1_s[0] = g1_s[0] | (p1_s[0] & cin_s);
    h2_s = x2_s ^ y2_s;
    g2_s = x2_s & y2_s;
    p2_s = x2_s | y2_s;
    g2_s[0] = g2_s[0] | (p2_s[0] & cin_s);
  end

  // Stage 1 registers: bitwise generate/propagate/half-sum for both vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      cin_r <= 1'b0;
      h1_r  <= '0;
      g1_r  <= '0;
      p1_r  <= '0;
      h2_r  <= '0;
      g2_r  <= '0;
      p2_r  <= '0;
    end else if (advance_s) begin
      v1_r  <= in_valid;
      cin_r <= cin_s;
      h1_r  <= h1_s;
      g1_r  <= g1_s;
      p1_r  <= p1_s;
      h2_r  <= h2_s;
      g2_r  <= g2_s;
      p2_r  <= p2_s;
    end
  end

  // Resolve group generates for both vectors through the prefix network.
  always_comb begin
    gc1_s = prefix_carry({1'b0, g1_r}, {1'b0, p1_r});
    gc2_s = prefix_carry(g2_r, p2_r);
  end

  // Stage 2 registers: carry into each bit position (bit 0 is the carry-in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      h1b_r  <= '0;
      h2b_r  <= '0;
      c1_r   <= '0;
      c2_r   <= '0;
`ifdef MOD_ADDER_SUB_EN
      sub2_r <= 1'b0;
`endif
    end else if (advance_s) begin
      v2_r   <= v1_r;
      h1b_r  <= h1_r;
      h2b_r  <= h2_r;
      c1_r   <= {gc1_s[WIDTH-1:0], cin_r};
      c2_r   <= {gc2_s[WIDTH-1:0], cin_r};
`ifdef MOD_ADDER_SUB_EN
      sub2_r <= cin_r;
`endif
    end
  end

  // Pick the reduced sum whenever reduction by M applies.
  always_comb begin
    sum1_s = h1b_r ^ c1_r[WIDTH-1:0];
    sum2_s = h2b_r[WIDTH-1:0] ^ c2_r[WIDTH-1:0];
`ifdef MOD_ADDER_SUB_EN
    if (sub2_r) begin
      wrap_s = ~c1_r[WIDTH];
    end else begin
      wrap_s = h2b_r[WIDTH] ^ c2_r[WIDTH];
    end
`else
    wrap_s = h2b_r[WIDTH] ^ c2_r[WIDTH];
`endif
    sum_s = wrap_s ? sum2_s : sum1_s;
  end

  // Stage 3 registers: the output slot, frozen while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      wrap      <= 1'b0;
    end else if (advance_s) begin
      out_valid <= v2_r;
      sum       <= sum_s;
      wrap      <= wrap_s;
    end
  end

  // Top group-generate bits fall beyond the WIDTH+1-bit sums and are dropped.
  logic unused_s;
`ifdef MOD_ADDER_SUB_EN
  assign unused_s = gc1_s[WIDTH] ^ gc2_s[WIDTH];
`else
  assign unused_s = gc1_s[WIDTH] ^ gc2_s[WIDTH] ^ c1_r[WIDTH];
`endif

endmodule

// File: tb/tb_mod_adder_pipe.sv
// Self-checking bench for mod_adder_pipe: directed vector table, k sweeps,
// backpressure, mid-flight reset; scoreboard queue compares results in order.
module tb_mod_adder_pipe;
  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic         wrap;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] k;
  logic [W-1:0] sum;
`ifdef MOD_ADDER_SUB_EN
  logic         sub;
`endif

  mod_adder_pipe #(.WIDTH(W), .PREFIX_KS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .k(k),
`ifdef MOD_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .wrap(wrap)
  );

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] k; logic s;
                   logic [W-1:0] sum; logic wrap; } vec_t;
  typedef struct { logic [W-1:0] sum; logic wrap; } exp_t;

  exp_t         sbq[$];
  int           acc_cyc[$];
  int           out_cyc[$];
  vec_t         tbl[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] exp_sum;
  logic         exp_wrap;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic [W-1:0] mk, input logic ms);
    logic [W:0] s1, s2, d;
    if (ms) begin
      d = {1'b0, ma} + {1'b0, ~mb} + {{W{1'b0}}, 1'b1};
      if (ma >= mb) model = {1'b0, d[W-1:0]};
      else begin
        d = d - {1'b0, mk};
        model = {1'b1, d[W-1:0]};
      end
    end else begin
      s1 = {1'b0, ma} + {1'b0, mb};
      s2 = s1 + {1'b0, mk};
      if (s2[W]) model = {1'b1, s2[W-1:0]};
      else model = {1'b0, s1[W-1:0]};
    end
  endfunction

  // Monitor: pop/compare on output transfer, push expectation on input transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got sum=%0d wrap=%0d, required no output", sum, wrap);
        end else begin
          e = sbq.pop_front();
          check("result", {wrap, sum}, {e.wrap, e.sum});
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{exp_sum, exp_wrap});
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Drive one transaction (called at posedge+1); returns one cycle after acceptance.
  task automatic send(input vec_t v);
    int waited;
    waited = 0;
    a = v.a; b = v.b; k = v.k;
`ifdef MOD_ADDER_SUB_EN
    sub = v.s;
`endif
    exp_sum = v.sum; exp_wrap = v.wrap;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("send_accept", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 60) begin
      waited++;
      @(negedge clk);
    end
    check("drain_empty", sbq.size(), 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic clear_timing();
    acc_cyc.delete();
    out_cyc.delete();
  endtask

  task automatic check_timing();
    check("timing_count", out_cyc.size(), acc_cyc.size());
    for (int i = 0; i < out_cyc.size() && i < acc_cyc.size(); i++) begin
      check("latency", out_cyc[i] - acc_cyc[i], 3);
      if (i > 0) check("consecutive", out_cyc[i] - out_cyc[i-1], 1);
    end
  endtask

  function automatic vec_t mk_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input logic [W-1:0] vk, input logic vs);
    vec_t v;
    logic [W:0] r;
    r = model(va, vb, vk, vs);
    v = '{va, vb, vk, vs, r[W-1:0], r[W]};
    return v;
  endfunction

  initial begin
    int   ks[4];
    int   m;
    vec_t v;
    vec_t bp[4];
    ks = '{0, 1, 63, 64};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; k = '0; exp_sum = '0; exp_wrap = 1'b0;
`ifdef MOD_ADDER_SUB_EN
    sub = 1'b0;
`endif
    // Directed vectors: {a, b, k, sub, expected sum, expected wrap}
    tbl.push_back('{7'd10,  7'd20,  7'd64,  1'b0, 7'd30,  1'b0});
    tbl.push_back('{7'd40,  7'd30,  7'd64,  1'b0, 7'd6,   1'b1});
    tbl.push_back('{7'd127, 7'd1,   7'd0,   1'b0, 7'd0,   1'b1});
    tbl.push_back('{7'd100, 7'd27,  7'd0,   1'b0, 7'd127, 1'b0});
    tbl.push_back('{7'd126, 7'd1,   7'd1,   1'b0, 7'd0,   1'b1});
    tbl.push_back('{7'd64,  7'd64,  7'd63,  1'b0, 7'd63,  1'b1});
    tbl.push_back('{7'd127, 7'd127, 7'd64,  1'b0, 7'd126, 1'b0});
    tbl.push_back('{7'd1,   7'd0,   7'd127, 1'b0, 7'd0,   1'b1});
    tbl.push_back('{7'd0,   7'd0,   7'd127, 1'b0, 7'd0,   1'b0});
    tbl.push_back('{7'd63,  7'd0,   7'd64,  1'b0, 7'd63,  1'b0});
`ifdef MOD_ADDER_SUB_EN
    tbl.push_back('{7'd5,   7'd10,  7'd64,  1'b1, 7'd59,  1'b1});
    tbl.push_back('{7'd10,  7'd5,   7'd64,  1'b1, 7'd5,   1'b0});
    tbl.push_back('{7'd7,   7'd7,   7'd64,  1'b1, 7'd0,   1'b0});
    tbl.push_back('{7'd0,   7'd127, 7'd0,   1'b1, 7'd1,   1'b1});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_wrap", wrap, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Directed table, back-to-back
    out_ready = 1'b1;
    clear_timing();
    foreach (tbl[i]) send(tbl[i]);
    in_valid = 1'b0;
    drain();
    check_timing();

    // Streams of 8 with in-range operands for each k
    foreach (ks[j]) begin
      clear_timing();
      m = 128 - ks[j];
      for (int i = 0; i < 8; i++) begin
        v = mk_vec(W'($urandom_range(0, m - 1)), W'($urandom_range(0, m - 1)), W'(ks[j]), 1'b0);
        send(v);
      end
      in_valid = 1'b0;
      drain();
      check_timing();
      check("stream_count", out_cyc.size(), 8);
    end

    // Backpressure: 3 in flight, stall 5 cycles, 4th item offered during stall
    clear_timing();
    bp[0] = mk_vec(7'd40, 7'd30, 7'd64, 1'b0);
    bp[1] = mk_vec(7'd10, 7'd20, 7'd64, 1'b0);
    bp[2] = mk_vec(7'd63, 7'd63, 7'd64, 1'b0);
    bp[3] = mk_vec(7'd1,  7'd2,  7'd64, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(bp[i]);
    a = bp[3].a; b = bp[3].b; k = bp[3].k;
    exp_sum = bp[3].sum; exp_wrap = bp[3].wrap;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold", {wrap, sum}, {bp[0].wrap, bp[0].sum});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_on_pop", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    check("bp_count", out_cyc.size(), 4);
    for (int i = 1; i < out_cyc.size(); i++) check("bp_consecutive", out_cyc[i] - out_cyc[i-1], 1);

    // Reset with 2 items in flight
    send(mk_vec(7'd11, 7'd22, 7'd64, 1'b0));
    send(mk_vec(7'd50, 7'd50, 7'd64, 1'b0));
    in_valid = 1'b0;
    rst_n = 1'b0;
    sbq.delete();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_wrap", wrap, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_timing();
    repeat (6) @(negedge clk);
    check("no_stale_output", out_cyc.size(), 0);
    @(posedge clk); #1;
    clear_timing();
    send(mk_vec(7'd33, 7'd44, 7'd64, 1'b0));
    in_valid = 1'b0;
    drain();
    check_timing();
    check("post_reset_count", out_cyc.size(), 1);

    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
